// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Host-fed instruction FIFO in front of a two-state issue engine.
//   Each cycle in RUN the FIFO head is popped into a registered
//   instruction output. A compute opcode (00001 / 00010) sends the engine
//   into STALL for COMPUTE_CYCLES NOP cycles before the next issue.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   host_instr   64-bit instruction word from host
//   host_valid   host_instr valid this cycle
//   host_ready   FIFO can accept a word this cycle
//   flush        synchronous discard of queued and pending work
//   instruction  registered word to controller (opcode [4:0], addr [10:5], data [42:11])
//   issue_valid  instruction carries a popped word
//   busy         engine is in STALL
//   fifo_count   current FIFO occupancy
module instr_sequencer #(
  parameter int DEPTH          = 8,
  parameter int COMPUTE_CYCLES = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [63:0]              host_instr,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic                     flush,
  output logic [63:0]              instruction,
  output logic                     issue_valid,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(COMPUTE_CYCLES) + 1;
  localparam logic [CW-1:0] FULL       = CW'(DEPTH);
  localparam logic [SW-1:0] STALL_LOAD = SW'(COMPUTE_CYCLES - 1);

  typedef enum logic {RUN, STALL} state_e;

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q, state_d;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic [63:0]   instr_q, instr_d;
  logic          valid_q, valid_d;

  logic          push, pop, head_compute;
  logic [63:0]   head;

  // rst is folded in so the host sees not-ready while reset is held.
  assign host_ready   = rst && !flush && (count_q != FULL);
  assign push         = host_valid && host_ready;
  // A word pushed this edge is not yet counted, so it can pop next edge at the earliest.
  assign pop          = (state_q == RUN) && (count_q != '0) && !flush;
  assign head         = mem_q[rd_ptr_q];
  assign head_compute = (head[4:0] == 5'b00001) || (head[4:0] == 5'b00010);

  assign instruction  = instr_q;
  assign issue_valid  = valid_q;
  assign busy         = (state_q == STALL);
  assign fifo_count   = count_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    instr_d     = '0;
    valid_d     = 1'b0;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      state_d     = RUN;
      stall_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        instr_d  = head;
        valid_d  = 1'b1;
        if (head_compute) begin
          state_d     = STALL;
          stall_cnt_d = STALL_LOAD;
        end
      end
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (state_q == STALL) begin
        if (stall_cnt_q == '0) state_d     = RUN;
        else                   stall_cnt_d = stall_cnt_q - SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= RUN;
      stall_cnt_q <= '0;
      instr_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
    end
  end

  // Storage needs no reset: pointers and count decide what is live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= host_instr;
  end

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;
  localparam int DEPTH = 8;
  localparam int CC    = 10;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int EW    = 64 + 1 + 1 + CW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [63:0]   host_instr = '0;
  logic          host_valid = 1'b0;
  logic          flush = 1'b0;
  logic          host_ready;
  logic [63:0]   instruction;
  logic          issue_valid;
  logic          busy;
  logic [CW-1:0] fifo_count;

  instr_sequencer #(.DEPTH(DEPTH), .COMPUTE_CYCLES(CC)) dut (
    .clk(clk), .rst(rst), .host_instr(host_instr), .host_valid(host_valid),
    .host_ready(host_ready), .flush(flush), .instruction(instruction),
    .issue_valid(issue_valid), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of pending words and a count of NOP cycles still owed.
  logic [63:0] mq[$];
  int          nops = 0;
  logic [63:0] exp_instr = '0;
  logic        exp_valid = 1'b0;
  logic        exp_ready, act_ready;

  function automatic logic [EW-1:0] model_out();
    return {exp_instr, exp_valid, (nops > 0) ? 1'b1 : 1'b0, CW'(mq.size())};
  endfunction

  function automatic logic [EW-1:0] dut_out();
    return {instruction, issue_valid, busy, fifo_count};
  endfunction

  function automatic logic [63:0] mk(input logic [4:0] op);
    logic [63:0] w;
    w = {$urandom, $urandom};
    w[4:0] = op;
    return w;
  endfunction

  function automatic logic [4:0] plain_op();
    logic [4:0] op;
    op = 5'($urandom_range(3, 31));
    return op;
  endfunction

  task automatic model_reset();
    mq.delete();
    nops = 0;
    exp_instr = '0;
    exp_valid = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model over the coming edge, then
  // land 1 time unit after that edge so outputs can be sampled.
  task automatic step(input logic v, input logic [63:0] w, input logic f);
    logic push;
    host_valid = v; host_instr = w; flush = f;
    #1;
    act_ready = host_ready;
    exp_ready = !f && (mq.size() < DEPTH);
    push = v && exp_ready;
    exp_instr = '0;
    exp_valid = 1'b0;
    if (f) begin
      mq.delete();
      nops = 0;
    end else begin
      if (nops > 0) nops--;
      else if (mq.size() > 0) begin
        exp_instr = mq.pop_front();
        exp_valid = 1'b1;
        if (exp_instr[4:0] == 5'd1 || exp_instr[4:0] == 5'd2) nops = CC;
      end
      if (push) mq.push_back(w);
    end
    @(posedge clk); #1;
    host_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_out() !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", dut_out()); end
    checks++;
    if (host_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", host_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (dut_out() !== model_out()) begin errors++; $display("FAIL reset_release: got %h want %h", dut_out(), model_out()); end
    checks++;
    if (host_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", host_ready); end
  endtask

  task automatic test_load_burst();
    int first_issue = -1;
    for (int c = 0; c < 8; c++) begin
      step(c < 4, mk(5'b00100), 1'b0);
      if (issue_valid === 1'b1 && first_issue < 0) first_issue = c;
      checks++;
      if (dut_out() !== model_out()) begin errors++; $display("FAIL load_burst c%0d: got %h want %h", c, dut_out(), model_out()); end
      checks++;
      if (act_ready !== exp_ready) begin errors++; $display("FAIL load_burst_ready c%0d: got %b want %b", c, act_ready, exp_ready); end
    end
    // first push edge is c=0, so the first issue lands on c=1
    checks++;
    if (first_issue != 1) begin errors++; $display("FAIL load_latency: got %0d want 1", first_issue); end
  endtask

  task automatic test_compute_stall();
    int t1 = -1, t2 = -1;
    logic [4:0] op1 = 5'h1f, op2 = 5'h1f;
    for (int c = 0; c < 16; c++) begin
      step(c < 2, mk(c == 0 ? 5'b00001 : 5'b00100), 1'b0);
      if (issue_valid === 1'b1) begin
        if (t1 < 0) begin t1 = c; op1 = instruction[4:0]; end
        else if (t2 < 0) begin t2 = c; op2 = instruction[4:0]; end
      end
      checks++;
      if (dut_out() !== model_out()) begin errors++; $display("FAIL compute_stall c%0d: got %h want %h", c, dut_out(), model_out()); end
    end
    checks++;
    if (t2 - t1 != CC + 1) begin errors++; $display("FAIL compute_gap: got %0d want %0d", t2 - t1, CC + 1); end
    checks++;
    if ({op1, op2} !== {5'b00001, 5'b00100}) begin errors++; $display("FAIL compute_order: got %h %h want 01 04", op1, op2); end
  endtask

  task automatic test_full();
    logic [63:0] ninth = mk(5'b00110);
    step(1'b1, mk(5'b00010), 1'b0);
    step(1'b0, '0, 1'b0);
    for (int c = 0; c < 8; c++) step(1'b1, mk(plain_op()), 1'b0);
    checks++;
    if (fifo_count !== CW'(8)) begin errors++; $display("FAIL full_count: got %0d want 8", fifo_count); end
    step(1'b1, ninth, 1'b0);
    checks++;
    if (act_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", act_ready); end
    for (int c = 0; c < 14; c++) begin
      step(1'b0, '0, 1'b0);
      checks++;
      if (dut_out() !== model_out()) begin errors++; $display("FAIL full_drain c%0d: got %h want %h", c, dut_out(), model_out()); end
      checks++;
      if (issue_valid === 1'b1 && instruction === ninth) begin errors++; $display("FAIL full_ninth_leaked: got %h want none", instruction); end
    end
    step(1'b1, ninth, 1'b0);
    step(1'b0, '0, 1'b0);
    checks++;
    if ({issue_valid, instruction} !== {1'b1, ninth}) begin errors++; $display("FAIL full_repush: got %b %h want 1 %h", issue_valid, instruction, ninth); end
  endtask

  task automatic test_flush();
    step(1'b1, mk(5'b00001), 1'b0);
    for (int c = 0; c < 6; c++) step(c > 0, mk(plain_op()), 1'b0);
    checks++;
    if ({busy, fifo_count} !== {1'b1, CW'(5)}) begin errors++; $display("FAIL flush_setup: got %b %0d want 1 5", busy, fifo_count); end
    step(1'b1, mk(5'b00100), 1'b1);
    checks++;
    if (act_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", act_ready); end
    checks++;
    if (dut_out() !== '0) begin errors++; $display("FAIL flush_outputs: got %h want 0", dut_out()); end
    for (int c = 0; c < 3; c++) begin
      step(1'b0, '0, 1'b0);
      checks++;
      if (dut_out() !== model_out()) begin errors++; $display("FAIL flush_after c%0d: got %h want %h", c, dut_out(), model_out()); end
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] fresh = mk(5'b00101);
    step(1'b1, mk(5'b00010), 1'b0);
    for (int c = 0; c < 4; c++) step(c > 0, mk(plain_op()), 1'b0);
    checks++;
    if ({busy, fifo_count} !== {1'b1, CW'(3)}) begin errors++; $display("FAIL mid_reset_setup: got %b %0d want 1 3", busy, fifo_count); end
    rst = 1'b0;
    model_reset();
    #2;
    checks++;
    if (dut_out() !== '0) begin errors++; $display("FAIL mid_reset_async: got %h want 0", dut_out()); end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(1'b0, '0, 1'b0);
      checks++;
      if (dut_out() !== model_out()) begin errors++; $display("FAIL mid_reset_idle c%0d: got %h want %h", c, dut_out(), model_out()); end
    end
    step(1'b1, fresh, 1'b0);
    step(1'b0, '0, 1'b0);
    checks++;
    if ({issue_valid, instruction} !== {1'b1, fresh}) begin errors++; $display("FAIL mid_reset_fresh: got %b %h want 1 %h", issue_valid, instruction, fresh); end
  endtask

  task automatic test_back_to_back();
    step(1'b1, mk(5'b00001), 1'b0);
    for (int c = 0; c < 4; c++) step(c > 0, mk(plain_op()), 1'b0);
    for (int g = 0; g < 40 && nops > 0; g++) step(1'b0, '0, 1'b0);
    for (int c = 0; c < 24; c++) begin
      step(1'b1, mk(plain_op()), 1'b0);
      checks++;
      if (dut_out() !== model_out()) begin errors++; $display("FAIL back_to_back c%0d: got %h want %h", c, dut_out(), model_out()); end
      checks++;
      if ({issue_valid, fifo_count} !== {1'b1, CW'(3)}) begin errors++; $display("FAIL back_to_back_steady c%0d: got %b %0d want 1 3", c, issue_valid, fifo_count); end
    end
    for (int g = 0; g < 40 && (mq.size() > 0 || nops > 0); g++) step(1'b0, '0, 1'b0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step(($urandom % 4) != 0, mk(5'($urandom % 32)), ($urandom % 60) == 0);
      checks++;
      if (dut_out() !== model_out()) begin errors++; $display("FAIL random c%0d: got %h want %h", c, dut_out(), model_out()); end
      checks++;
      if (act_ready !== exp_ready) begin errors++; $display("FAIL random_ready c%0d: got %b want %b", c, act_ready, exp_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_load_burst();
    test_compute_stall();
    test_full();
    test_flush();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: instruction FIFO entries, power of two, minimum 2.
REQ-002 SHALL have parameter COMPUTE_CYCLES, default 10: NOP cycles inserted after a compute instruction, minimum 1.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port host_instr, input, 64: instruction word from host.
REQ-006 SHALL have port host_valid, input, 1: host_instr valid this cycle.
REQ-007 SHALL have port host_ready, output, 1: FIFO can accept a word this cycle.
REQ-008 SHALL have port flush, input, 1: synchronous discard of all queued and pending work.
REQ-009 SHALL have port instruction, output, 64: registered instruction to the controller; opcode is [4:0], address [10:5], data [42:11].
REQ-010 SHALL have port issue_valid, output, 1: registered; high when instruction carries a popped word.
REQ-011 SHALL have port busy, output, 1: high while in STALL.
REQ-012 SHALL have port fifo_count, output, $clog2(DEPTH)+1: current FIFO occupancy.

Function
REQ-013 SHALL accept a push on a rising edge when host_valid and host_ready are both high; host_ready = (fifo_count != DEPTH) and flush low.
REQ-014 SHALL not accept a push when full, even if a pop occurs on the same edge.
REQ-015 SHALL wrap the read and write pointers modulo DEPTH.
REQ-016 SHALL adjust fifo_count by +1 on push only, -1 on pop only, and 0 on simultaneous push and pop.
REQ-017 SHALL implement two states, RUN and STALL.
REQ-018 In RUN with the FIFO non-empty, SHALL pop the head on the edge and register it onto instruction, with issue_valid=1.
REQ-019 In RUN with the FIFO empty, SHALL drive instruction=64'h0 (opcode 00000, NOP) and issue_valid=0.
REQ-020 SHALL move RUN->STALL when the popped word has opcode 5'b00001 or 5'b00010, loading the stall counter with COMPUTE_CYCLES-1.
REQ-021 In STALL, SHALL drive instruction=0 and issue_valid=0, pop nothing, and decrement the counter each edge.
REQ-022 In STALL with counter==0, SHALL return to RUN on that edge; exactly COMPUTE_CYCLES NOP cycles separate a compute issue from the next issue.
REQ-023 SHALL treat a push to an empty FIFO as issuable no earlier than the following edge: two edges from host_valid to instruction.
REQ-024 SHALL issue every non-compute opcode (00011, 00100, 00101, 00110, 00111, and unknown codes) back-to-back, one per cycle, without stall.
REQ-025 When flush is high, SHALL on the next edge empty the FIFO, drop any simultaneous push, force RUN with the counter cleared, and drive instruction=0, issue_valid=0.
REQ-026 SHALL preserve issue order equal to push order.

Reset
REQ-027 While rst=0, SHALL asynchronously force instruction=0, issue_valid=0, busy=0, fifo_count=0, both pointers=0, state RUN, counter=0; host_ready=0 during reset.
REQ-028 SHALL discard FIFO contents and any in-progress stall on reset assertion mid-operation; the first issue after release comes from a new push.

Verification
REQ-029 Reset mid-STALL with 3 entries queued, then release -> all outputs 0, fifo_count=0, no stale word issued.
REQ-030 Push 4 load-input words (opcode 00100) on consecutive cycles -> issued on 4 consecutive cycles, in order, starting 2 edges after the first push.
REQ-031 Push 00001 then 00100, with COMPUTE_CYCLES=10 -> 00001 issued, busy high, exactly 10 NOP cycles, then 00100 issued.
REQ-032 Stall the output, push 8 words -> fifo_count=8, host_ready=0; a 9th valid word is not accepted; after draining, the 9th word is issued only after it is re-pushed.
REQ-033 With fifo_count=5 during STALL, assert flush together with host_valid -> next cycle fifo_count=0, busy=0, instruction=0, pushed word lost.
REQ-034 Run 20 or more push/pop cycles across pointer wrap with simultaneous push and pop -> fifo_count stays constant; issued order and data match the pushes.
